// File: rtl/muldiv_seq_unit.sv
// Sequential multiply/divide unit: shift-add multiply and restoring divide, one bit
// per clock, with registered HI/LO results behind a start/busy/done handshake.
module muldiv_seq_unit #(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; done pulses here for one cycle after FIX
  // PREP  | take magnitudes, record signs, load counter (b=0 divide skips to FIX)
  // CALC  | one multiply/divide iteration per cycle, WIDTH cycles
  // FIX   | restore signs and write hi/lo
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [1:0]         rst_sync;
  logic               rst_i;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_res, neg_rem, div0_q;

  logic               is_signed, is_div;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  assign is_signed = (SIGNED_EN != 0) && op_q[0];
  assign is_div    = op_q[1];
  assign a_abs     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  // The partial remainder is always below the divisor, so bit WIDTH of the
  // difference is a clean borrow flag.
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      div0_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q        <= op;
            a_q         <= a;
            b_q         <= b;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= PREP;
          end
        end
        PREP: begin
          neg_res <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem <= is_signed && a_q[WIDTH-1];
          cnt     <= CW'(WIDTH-1);
          if (is_div && (b_q == '0)) begin
            div0_q <= 1'b1;
            state  <= FIX;
          end else begin
            div0_q <= 1'b0;
            a_q    <= a_abs;
            b_q    <= b_abs;
            acc    <= is_div ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
            state  <= CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (div0_q) begin
            hi          <= a_q;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: signed and unsigned instances share stimulus.
module tb_muldiv_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] hi, lo;
  logic        busy_u, done_u, dz_u;
  logic [15:0] hi_u, lo_u;

  int checks = 0;
  int errors = 0;
  int lat, bcnt;
  logic seen_done;

  muldiv_seq_unit #(.WIDTH(16), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo));

  muldiv_seq_unit #(.WIDTH(16), .SIGNED_EN(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy_u), .done(done_u), .div_by_zero(dz_u), .hi(hi_u), .lo(lo_u));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0 (acceptance).
  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       output int l, output int bc);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l  = 1;
    bc = busy ? 1 : 0;
    while (!done && l < 200) begin
      @(posedge clk); #1;
      l++;
      if (busy) bc++;
    end
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz",   {31'b0, div_by_zero}, 32'd0);
    chk("rst_hi",   {16'b0, hi}, 32'd0);
    chk("rst_lo",   {16'b0, lo}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    do_op(2'b00, 16'hFFFF, 16'hFFFF, lat, bcnt);
    chk("multu_lat",  lat, 32'd19);
    chk("multu_busy", bcnt, 32'd18);
    chk("multu_busy_done", {31'b0, busy}, 32'd0);
    chk("multu_hi", {16'b0, hi}, 32'h0000FFFE);
    chk("multu_lo", {16'b0, lo}, 32'h00000001);

    do_op(2'b01, 16'hFFFD, 16'h0005, lat, bcnt);
    chk("mult_lat", lat, 32'd19);
    chk("mult_hi", {16'b0, hi}, 32'h0000FFFF);
    chk("mult_lo", {16'b0, lo}, 32'h0000FFF1);
    chk("mult_u_done", {31'b0, done_u}, 32'd1);
    chk("mult_u_hi", {16'b0, hi_u}, 32'h00000004);
    chk("mult_u_lo", {16'b0, lo_u}, 32'h0000FFF1);

    do_op(2'b10, 16'd100, 16'd7, lat, bcnt);
    chk("divu_lat", lat, 32'd19);
    chk("divu_lo", {16'b0, lo}, 32'h0000000E);
    chk("divu_hi", {16'b0, hi}, 32'h00000002);
    chk("divu_dz", {31'b0, div_by_zero}, 32'd0);

    do_op(2'b11, 16'hFFF9, 16'h0002, lat, bcnt);
    chk("div_lo", {16'b0, lo}, 32'h0000FFFD);
    chk("div_hi", {16'b0, hi}, 32'h0000FFFF);
    chk("div_u_lo", {16'b0, lo_u}, 32'h00007FFC);
    chk("div_u_hi", {16'b0, hi_u}, 32'h00000001);

    do_op(2'b11, 16'h8000, 16'hFFFF, lat, bcnt);
    chk("div_ovf_lo", {16'b0, lo}, 32'h00008000);
    chk("div_ovf_hi", {16'b0, hi}, 32'h00000000);
    chk("div_ovf_dz", {31'b0, div_by_zero}, 32'd0);

    do_op(2'b10, 16'h1234, 16'h0000, lat, bcnt);
    chk("dz_lat", lat, 32'd3);
    chk("dz_hi", {16'b0, hi}, 32'h00001234);
    chk("dz_lo", {16'b0, lo}, 32'h0000FFFF);
    chk("dz_flag", {31'b0, div_by_zero}, 32'd1);

    // Start in the done cycle is accepted and clears the flag next cycle.
    op = 2'b10; a = 16'd100; b = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dz_clear", {31'b0, div_by_zero}, 32'd0);
    chk("dz_clear_busy", {31'b0, busy}, 32'd1);
    chk("dz_clear_hold_hi", {16'b0, hi}, 32'h00001234);
    lat = 1;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("b2b_lat", lat, 32'd19);
    chk("b2b_lo", {16'b0, lo}, 32'h0000000E);

    // Start pulse at cycle 5 of a multiply must be ignored.
    op = 2'b00; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    op = 2'b10; a = 16'h0003; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("ign_lat", lat, 32'd19);
    chk("ign_hi", {16'b0, hi}, 32'h0000FFFE);
    chk("ign_lo", {16'b0, lo}, 32'h00000001);
    chk("ign_dz", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    chk("ign_no_restart", {31'b0, busy}, 32'd0);

    // Reset in the middle of CALC aborts.
    op = 2'b00; a = 16'h1234; b = 16'h0056; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", {16'b0, hi}, 32'd0);
    chk("abort_lo", {16'b0, lo}, 32'd0);
    #10 rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen_done = 1'b1; end
    chk("abort_no_done", {31'b0, seen_done}, 32'd0);

    do_op(2'b10, 16'd9, 16'd3, lat, bcnt);
    chk("post_lat", lat, 32'd19);
    chk("post_lo", {16'b0, lo}, 32'h00000003);
    chk("post_hi", {16'b0, hi}, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
